// File: rtl/dac60508_spi_rx_if.sv
// SPI link between the DAC driver (master) and the receiver/monitor (slave).
interface dac60508_spi_rx_if;
  logic CS;
  logic SCLK;
  logic MOSI;

  modport master (output CS, SCLK, MOSI);
  modport slave  (input  CS, SCLK, MOSI);
endinterface

// File: rtl/dac60508_spi_rx.sv
// DAC60508MC write-frame receiver. Oversamples CS/SCLK/MOSI in the core
// domain, decodes 24-bit write frames and mirrors DAC0..DAC7 data.
//
// state | meaning
// IDLE  | waiting for CS to fall
// SHIFT | capturing MOSI on each SCLK falling edge
// CHECK | one cycle: judge the captured frame and publish the result
module dac60508_spi_rx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dac60508_spi_rx_if.slave      spi,
  output logic                  frame_valid,
  output logic [3:0]            frame_addr,
  output logic [15:0]           frame_data,
  output logic                  frame_err,
  output logic [7:0]            err_cnt,
  output logic [127:0]          dac_shadow,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, mosi_sync;
  logic                    cs_hist, sclk_hist;
  logic                    cs_s, sclk_s, mosi_s;
  logic                    cs_fall, cs_rise, sclk_fall;
  logic [23:0]             sreg;
  logic [4:0]              bit_cnt;
  logic                    addr_ok, frame_good;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall   = !cs_s && cs_hist;
  assign cs_rise   = cs_s && !cs_hist;
  assign sclk_fall = !sclk_s && sclk_hist;

  // Writable targets: 2..6 are control registers, 8..F are DAC0..DAC7.
  assign addr_ok    = sreg[19] || (sreg[19:16] >= 4'd2 && sreg[19:16] <= 4'd6);
  assign frame_good = (bit_cnt == 5'(FRAME_BITS)) && !sreg[23] && addr_ok;

  assign busy = (state != IDLE);

  // Synchronizer chains plus one history flop for edge detection; MOSI
  // shares SCLK's depth so it is aligned with the detected falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_hist   <= 1'b0;
      sclk_hist <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      cs_hist   <= cs_s;
      sclk_hist <= sclk_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a cs_fall seen in CHECK is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift/count during the frame, then publish the decoded result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg        <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      err_cnt     <= '0;
      dac_shadow  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            sreg    <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            sreg <= {sreg[22:0], mosi_s};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        CHECK: begin
          frame_addr <= sreg[19:16];
          frame_data <= sreg[15:0];
          if (frame_good) begin
            frame_valid <= 1'b1;
            if (sreg[19]) dac_shadow[{sreg[18:16], 4'b0000} +: 16] <= sreg[15:0];
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
